// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg: state encoding and default widths shared by the memory stage
// and its neighbouring EX/MEM and MEM/WB interfaces.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  localparam int unsigned C_DATA_W_DEF = 16;
  localparam int unsigned C_ADDR_W_DEF = 16;
  localparam int unsigned C_REG_AW_DEF = 3;
  localparam int unsigned C_MAX_WAIT_DEF = 8;

  typedef enum logic [0:0] {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } ms_state_e;

endpackage : mem_stage_pkg

`default_nettype wire

// File: rtl/mem_stage_mc.sv
// ============================================================================
// mem_stage_mc: memory stage with variable-latency data-memory handshake,
// alignment check, access timeout and built-in MEM/WB register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = C_DATA_W_DEF,
  parameter int unsigned ADDR_W      = C_ADDR_W_DEF,
  parameter int unsigned REG_AW      = C_REG_AW_DEF,
  parameter int unsigned MAX_WAIT    = C_MAX_WAIT_DEF,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              reg_write,
  input  logic              mem_en,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              dump,
  input  logic [REG_AW-1:0] rd_addr,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_dump,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              out_valid,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write_out,
  output logic [REG_AW-1:0] rd_addr_out,
  output logic              dump_out,
  output logic              err_out
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_WAIT - 1);

  ms_state_e         state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  // Latched request: address/data/control of the outstanding memory op.
  logic [DATA_W-1:0] lat_alu_q, lat_alu_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [REG_AW-1:0] lat_rd_q, lat_rd_d;
  logic              lat_wr_q, lat_wr_d;
  logic              lat_dump_q, lat_dump_d;
  logic              lat_rw_q, lat_rw_d;
  logic              lat_m2r_q, lat_m2r_d;

  // MEM/WB register.
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              reg_write_out_q, reg_write_out_d;
  logic [REG_AW-1:0] rd_addr_out_q, rd_addr_out_d;
  logic              dump_out_q, dump_out_d;
  logic              err_out_q, err_out_d;

  logic              w_misalign;
  logic              w_timeout;

  assign w_misalign = ALIGN_CHECK && alu_res[0];
  assign w_timeout  = (wait_cnt_q == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= MS_IDLE;
      wait_cnt_q      <= '0;
      lat_alu_q       <= '0;
      lat_wdata_q     <= '0;
      lat_rd_q        <= '0;
      lat_wr_q        <= 1'b0;
      lat_dump_q      <= 1'b0;
      lat_rw_q        <= 1'b0;
      lat_m2r_q       <= 1'b0;
      out_valid_q     <= 1'b0;
      write_data_q    <= '0;
      reg_write_out_q <= 1'b0;
      rd_addr_out_q   <= '0;
      dump_out_q      <= 1'b0;
      err_out_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      lat_alu_q       <= lat_alu_d;
      lat_wdata_q     <= lat_wdata_d;
      lat_rd_q        <= lat_rd_d;
      lat_wr_q        <= lat_wr_d;
      lat_dump_q      <= lat_dump_d;
      lat_rw_q        <= lat_rw_d;
      lat_m2r_q       <= lat_m2r_d;
      out_valid_q     <= out_valid_d;
      write_data_q    <= write_data_d;
      reg_write_out_q <= reg_write_out_d;
      rd_addr_out_q   <= rd_addr_out_d;
      dump_out_q      <= dump_out_d;
      err_out_q       <= err_out_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    lat_alu_d       = lat_alu_q;
    lat_wdata_d     = lat_wdata_q;
    lat_rd_d        = lat_rd_q;
    lat_wr_d        = lat_wr_q;
    lat_dump_d      = lat_dump_q;
    lat_rw_d        = lat_rw_q;
    lat_m2r_d       = lat_m2r_q;
    out_valid_d     = 1'b0;
    err_out_d       = 1'b0;
    write_data_d    = write_data_q;
    reg_write_out_d = reg_write_out_q;
    rd_addr_out_d   = rd_addr_out_q;
    dump_out_d      = dump_out_q;

    case (state_q)
      MS_IDLE: begin
        if (in_valid) begin
          if (!mem_en) begin
            out_valid_d     = 1'b1;
            write_data_d    = alu_res;
            reg_write_out_d = reg_write;
            rd_addr_out_d   = rd_addr;
            dump_out_d      = dump;
          end else if (w_misalign) begin
            out_valid_d     = 1'b1;
            err_out_d       = 1'b1;
            write_data_d    = alu_res;
            reg_write_out_d = 1'b0;
            rd_addr_out_d   = rd_addr;
            dump_out_d      = dump;
          end else begin
            state_d     = MS_WAIT;
            wait_cnt_d  = '0;
            lat_alu_d   = alu_res;
            lat_wdata_d = rt_data;
            lat_rd_d    = rd_addr;
            lat_wr_d    = mem_write;
            lat_dump_d  = dump;
            lat_rw_d    = reg_write;
            lat_m2r_d   = mem_to_reg;
          end
        end
      end
      MS_WAIT: begin
        // A completing access takes priority over a simultaneous timeout.
        if (mem_done) begin
          state_d         = MS_IDLE;
          out_valid_d     = 1'b1;
          write_data_d    = lat_m2r_q ? mem_rdata : lat_alu_q;
          reg_write_out_d = lat_rw_q;
          rd_addr_out_d   = lat_rd_q;
          dump_out_d      = lat_dump_q;
        end else if (w_timeout) begin
          state_d         = MS_IDLE;
          out_valid_d     = 1'b1;
          err_out_d       = 1'b1;
          write_data_d    = lat_alu_q;
          reg_write_out_d = 1'b0;
          rd_addr_out_d   = lat_rd_q;
          dump_out_d      = lat_dump_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  assign in_ready      = (state_q == MS_IDLE);
  assign mem_req       = (state_q == MS_WAIT);
  assign mem_wr        = mem_req & lat_wr_q;
  assign mem_dump      = mem_req & lat_dump_q;
  assign mem_addr      = lat_alu_q[ADDR_W-1:0];
  assign mem_wdata     = lat_wdata_q;
  assign out_valid     = out_valid_q;
  assign write_data    = write_data_q;
  assign reg_write_out = reg_write_out_q;
  assign rd_addr_out   = rd_addr_out_q;
  assign dump_out      = dump_out_q;
  assign err_out       = err_out_q;

endmodule : mem_stage_mc

`default_nettype wire

// File: tb/tb_mem_stage_mc.sv
// ============================================================================
// tb_mem_stage_mc: directed vectors and multi-cycle sequences for mem_stage_mc.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_mc;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] rt_data;
  logic              reg_write, mem_en, mem_write, mem_to_reg, dump;
  logic [REG_AW-1:0] rd_addr;
  logic              mem_req, mem_wr, mem_dump;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              out_valid;
  logic [DATA_W-1:0] write_data;
  logic              reg_write_out;
  logic [REG_AW-1:0] rd_addr_out;
  logic              dump_out;
  logic              err_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_mc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW),
    .MAX_WAIT(MAX_WAIT), .ALIGN_CHECK(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .rt_data(rt_data), .reg_write(reg_write),
    .mem_en(mem_en), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .dump(dump), .rd_addr(rd_addr), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dump(mem_dump),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .out_valid(out_valid),
    .write_data(write_data), .reg_write_out(reg_write_out),
    .rd_addr_out(rd_addr_out), .dump_out(dump_out), .err_out(err_out)
  );

  typedef struct {
    logic              vld;
    logic [DATA_W-1:0] alu;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              men;
    logic              m2r;
    logic              dmp;
    logic              e_valid;
    logic [DATA_W-1:0] e_wd;
    logic              e_rw;
    logic [REG_AW-1:0] e_rd;
    logic              e_dump;
    logic              e_err;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; alu_res = '0; rt_data = '0; reg_write = 1'b0;
    mem_en = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; dump = 1'b0;
    rd_addr = '0; mem_rdata = '0; mem_done = 1'b0;
  endtask

  task automatic issue_mem(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic wr, input logic rw, input logic [REG_AW-1:0] rd);
    in_valid = 1'b1; alu_res = a; rt_data = d; mem_en = 1'b1; mem_write = wr;
    mem_to_reg = ~wr; reg_write = rw; rd_addr = rd; dump = 1'b0;
    tick();
    idle_inputs();
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 16'h1234, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 16'h1234, 1'b1, 3'd3, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'hABCD, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b1, 16'hABCD, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h0041, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0,
                1'b1, 16'h0041, 1'b0, 3'd2, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 16'h5555, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1,
                1'b0, 16'h0041, 1'b0, 3'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h0007, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 16'h0007, 1'b1, 3'd7, 1'b0, 1'b0};

    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_err", err_out, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Single-cycle instructions back to back
    for (int i = 0; i < 5; i++) begin
      in_valid = vecs[i].vld; alu_res = vecs[i].alu; rd_addr = vecs[i].rd;
      reg_write = vecs[i].rw; mem_en = vecs[i].men; mem_to_reg = vecs[i].m2r;
      dump = vecs[i].dmp;
      tick();
      chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_wd", i), write_data, vecs[i].e_wd);
      chk($sformatf("v%0d_rw", i), reg_write_out, vecs[i].e_rw);
      chk($sformatf("v%0d_rd", i), rd_addr_out, vecs[i].e_rd);
      chk($sformatf("v%0d_dump", i), dump_out, vecs[i].e_dump);
      chk($sformatf("v%0d_err", i), err_out, vecs[i].e_err);
      chk($sformatf("v%0d_req", i), mem_req, 0);
      chk($sformatf("v%0d_ready", i), in_ready, 1);
    end
    idle_inputs();
    tick();
    chk("idle_valid_drop", out_valid, 0);

    // Load with done in the third request cycle
    issue_mem(16'h0040, 16'h0000, 1'b0, 1'b1, 3'd4);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("ld_c%0d_ready", c), in_ready, 0);
      chk($sformatf("ld_c%0d_req", c), mem_req, 1);
      chk($sformatf("ld_c%0d_addr", c), mem_addr, 16'h0040);
      chk($sformatf("ld_c%0d_wr", c), mem_wr, 0);
      chk($sformatf("ld_c%0d_valid", c), out_valid, 0);
      if (c == 3) begin mem_done = 1'b1; mem_rdata = 16'hBEEF; end
      tick();
    end
    mem_done = 1'b0; mem_rdata = '0;
    chk("ld_valid", out_valid, 1);
    chk("ld_wd", write_data, 16'hBEEF);
    chk("ld_rw", reg_write_out, 1);
    chk("ld_rd", rd_addr_out, 4);
    chk("ld_err", err_out, 0);
    chk("ld_ready", in_ready, 1);
    chk("ld_req_drop", mem_req, 0);

    // Store completing in the first wait cycle
    issue_mem(16'h0010, 16'h00FF, 1'b1, 1'b0, 3'd1);
    chk("st_req", mem_req, 1);
    chk("st_wr", mem_wr, 1);
    chk("st_addr", mem_addr, 16'h0010);
    chk("st_wdata", mem_wdata, 16'h00FF);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("st_valid", out_valid, 1);
    chk("st_rw", reg_write_out, 0);
    chk("st_wd", write_data, 16'h0010);
    chk("st_err", err_out, 0);

    // Timeout: request held exactly MAX_WAIT cycles, then error pulse
    issue_mem(16'h0020, 16'h0000, 1'b0, 1'b1, 3'd6);
    n = 0;
    for (int c = 0; c < 20 && mem_req; c++) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, MAX_WAIT);
    chk("to_valid", out_valid, 1);
    chk("to_err", err_out, 1);
    chk("to_rw", reg_write_out, 0);
    chk("to_ready", in_ready, 1);
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_done = 1'b0; mem_rdata = '0;
    chk("stray_valid", out_valid, 0);
    chk("stray_err", err_out, 0);
    chk("stray_req", mem_req, 0);
    chk("stray_wd", write_data, 16'h0020);

    // Done in the last allowed cycle beats the timeout
    issue_mem(16'h0030, 16'h0000, 1'b0, 1'b1, 3'd2);
    for (int c = 1; c < MAX_WAIT; c++) tick();
    chk("late_req", mem_req, 1);
    mem_done = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_done = 1'b0; mem_rdata = '0;
    chk("late_valid", out_valid, 1);
    chk("late_err", err_out, 0);
    chk("late_wd", write_data, 16'hCAFE);
    chk("late_rw", reg_write_out, 1);

    // Reset in the second wait cycle
    issue_mem(16'h0050, 16'h1111, 1'b1, 1'b1, 3'd5);
    tick();
    chk("rw_req_before", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req", mem_req, 0);
    chk("rw_wr", mem_wr, 0);
    chk("rw_addr", mem_addr, 0);
    chk("rw_wdata", mem_wdata, 0);
    chk("rw_wd", write_data, 0);
    chk("rw_rd", rd_addr_out, 0);
    chk("rw_ready", in_ready, 1);
    n = 0;
    mem_done = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) n++;
      tick();
    end
    mem_done = 1'b0;
    chk("rw_no_valid", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_stage_mc

`default_nettype wire
